lsu_align_unit: RTL
===================

Name: lsu_align_unit

Overview:
Parametrised load/store alignment unit between the execute stage and a word-wide data memory port. It handles every RV32I/RV64I load and store width: byte-lane extraction, sign/zero extension, store byte-enable and data shifting. It adds what the combinational load extractor lacked: store support, a valid/ready request and response handshake, and optional splitting of misaligned accesses into two memory beats.

Parameters:
DATA_W, 32, memory and register data width; 32 or 64 only (BYTES = DATA_W/8, OFF_W = log2(BYTES)).
ADDR_W, 32, byte address width.
SPLIT_EN, 1, 1 = misaligned accesses split into two beats; 0 = misaligned access returns rsp_err with no memory access.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  synchronous, active-low reset.
req_valid  in  1  request from execute stage.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_func3  in  3  RISC-V funct3 width/sign code.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
mem_req_valid  out  1  memory beat request.
mem_req_ready  in  1  memory accepts beat.
mem_addr  out  ADDR_W  beat address; low OFF_W bits always 0.
mem_we  out  1  beat is a write.
mem_be  out  BYTES  byte enables, valid for writes and reads.
mem_wdata  out  DATA_W  lane-aligned write data.
mem_rvalid  in  1  read data valid, or write acknowledge.
mem_rdata  in  DATA_W  read data.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer takes response.
rsp_data  out  DATA_W  extended load result; 0 for stores and errors.
rsp_err  out  1  misaligned access with SPLIT_EN=0, or illegal func3.

Behaviour:
- Reset (rst_n low at a clock edge, any state): FSM goes to IDLE. All outputs 0 except req_ready = 1. The beat counter and captured data are cleared.
- Legal func3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With DATA_W=64 also 011 LD and 110 LWU.
- Legal func3, stores: 000 SB, 001 SH, 010 SW. With DATA_W=64 also 011 SD.
- All other func3 values are illegal.
- size = 1, 2, 4 or 8 bytes. off = req_addr[OFF_W-1:0]. cross = (off + size > BYTES).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid & req_ready, latch the request.
  - Illegal func3, or cross with SPLIT_EN=0: go to RESP with rsp_err=1. No mem_req_valid is ever raised.
  - Otherwise go to REQ0.
- REQ0: mem_req_valid=1, mem_addr = addr with low OFF_W bits cleared. Hold all beat outputs stable until mem_req_ready, then go to WAIT0.
- WAIT0: on mem_rvalid, capture mem_rdata into lo. Go to REQ1 if cross, else RESP.
- REQ1 / WAIT1: same as REQ0 / WAIT0 with mem_addr = aligned addr + BYTES. Capture into hi, then go to RESP.
- Ordering: the memory returns exactly one mem_rvalid per accepted beat, in order. mem_rvalid outside WAIT0/WAIT1 is ignored.
- Store lanes: form the 2*BYTES-wide enable ((1<<size)-1) << off and the 2*DATA_W-wide data req_wdata << (8*off).
  - Beat0 uses the low halves; beat1 uses the high halves.
  - Enable bits for absent bytes are 0. Data bytes in disabled lanes are 0.
- Load extraction: window = {hi, lo} >> (8*off), taking the low size bytes.
  - Signed codes sign-extend from the top kept bit; unsigned codes zero-extend.
  - When not cross, hi is ignored.
- RESP: rsp_valid=1; rsp_data and rsp_err are registered and held stable until rsp_ready, then return to IDLE.
- req_ready is 0 in RESP, so back-to-back throughput is one access per 4 cycles unsplit, assuming single-cycle memory.
- Minimum latency, aligned access with zero-wait memory:
  - accept at cycle 0, mem_req_valid at cycle 1, mem_rvalid sampled at cycle 2, rsp_valid at cycle 3.
- Error responses assert rsp_valid in the cycle after acceptance.
- Address wrap: aligned addr + BYTES wraps modulo 2^ADDR_W.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams (F3_LB … F3_SD).
  - state enum typedef.
  - size-decode function returning byte count and signedness.
- One natural combinational sub-module, lsu_lane_shift: store enable/data shifting and load window extraction/extension, parametrised by DATA_W.
- FSM and registers stay in the top module.

Test Plan:
- DATA_W=32, LB addr 0x103, mem word at 0x100 = 0x80FF1234 -> one beat at 0x100, be 1111, rsp_data 0xFFFFFF80, rsp_err 0.
- LHU addr 0x102, word 0xBEEF0000 -> rsp_data 0x0000BEEF.
- SPLIT_EN=1, LW addr 0x101, words 0x100=0x44332211 and 0x104=0x88776655 -> beats at 0x100 then 0x104, rsp_data 0x55443322.
- SH addr 0x003, wdata 0x0000ABCD:
  - beat0: addr 0x0, be 1000, wdata 0xCD000000.
  - beat1: addr 0x4, be 0001, wdata 0x000000AB.
  - rsp_data 0.
- SPLIT_EN=0, LW addr 0x002 -> mem_req_valid never asserted, rsp_valid next cycle with rsp_err 1. Also func3=111 -> rsp_err 1.
- mem_req_ready held low 3 cycles in REQ0 -> beat outputs stable throughout.
- rst_n low during WAIT0, then a late mem_rvalid -> FSM in IDLE, rsp_valid 0, late mem_rvalid ignored.
- rsp_ready low 2 cycles -> rsp_data held and req_ready stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes,
// FSM state encoding and the width/sign decoder.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic       sgn;
    logic [3:0] size;
  } lsu_dec_t;

  // wide = 1 enables the doubleword / LWU encodings of a 64-bit datapath
  function automatic lsu_dec_t size_decode(input logic we, input logic [2:0] f3,
                                           input logic wide);
    lsu_dec_t d;
    d.legal = 1'b0;
    d.sgn   = 1'b0;
    d.size  = 4'd1;
    if (we) begin
      case (f3)
        F3_SB: begin d.legal = 1'b1; d.size = 4'd1; end
        F3_SH: begin d.legal = 1'b1; d.size = 4'd2; end
        F3_SW: begin d.legal = 1'b1; d.size = 4'd4; end
        F3_SD: begin d.legal = wide; d.size = 4'd8; end
        default: ;
      endcase
    end else begin
      case (f3)
        F3_LB:  begin d.legal = 1'b1; d.sgn = 1'b1; d.size = 4'd1; end
        F3_LH:  begin d.legal = 1'b1; d.sgn = 1'b1; d.size = 4'd2; end
        F3_LW:  begin d.legal = 1'b1; d.sgn = 1'b1; d.size = 4'd4; end
        F3_LD:  begin d.legal = wide; d.sgn = 1'b1; d.size = 4'd8; end
        F3_LBU: begin d.legal = 1'b1; d.size = 4'd1; end
        F3_LHU: begin d.legal = 1'b1; d.size = 4'd2; end
        F3_LWU: begin d.legal = wide; d.size = 4'd4; end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational byte-lane steering: store enables/data across two beats and
// load window extraction with sign/zero extension.
module lsu_lane_shift #(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [3:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic [BYTES-1:0]  be_lo,
  output logic [BYTES-1:0]  be_hi,
  output logic [DATA_W-1:0] wd_lo,
  output logic [DATA_W-1:0] wd_hi,
  output logic [DATA_W-1:0] ldata
);

  logic [2*BYTES-1:0]  base_m;
  logic [2*BYTES-1:0]  be2;
  logic [2*DATA_W-1:0] wd_raw;
  logic [2*DATA_W-1:0] wd2;
  logic [DATA_W-1:0]   win;
  logic [OFF_W+2:0]    bsh;
  logic [OFF_W+3:0]    hsh;
  logic                top;
  logic                sbit;

  assign bsh = {off, 3'b000};
  assign hsh = (OFF_W+4)'(DATA_W) - (OFF_W+4)'(bsh);

  always_comb begin
    base_m = '0;
    for (int i = 0; i < 2*BYTES; i++) base_m[i] = (5'(i) < {1'b0, size});
  end

  assign be2    = base_m << off;
  assign wd_raw = {{DATA_W{1'b0}}, wdata} << bsh;

  // zero data in lanes whose enable is off so stray upper store bits never leak
  for (genvar b = 0; b < 2*BYTES; b++) begin : g_st_lane
    assign wd2[8*b +: 8] = be2[b] ? wd_raw[8*b +: 8] : 8'h00;
  end

  assign be_lo = be2[BYTES-1:0];
  assign be_hi = be2[2*BYTES-1:BYTES];
  assign wd_lo = wd2[DATA_W-1:0];
  assign wd_hi = wd2[2*DATA_W-1:DATA_W];

  // shift by DATA_W (off == 0) yields zero, so hi drops out for aligned windows
  assign win = (lo >> bsh) | (hi << hsh);

  always_comb begin
    case (size)
      4'd1:    top = win[7];
      4'd2:    top = win[15];
      4'd4:    top = win[31];
      default: top = win[DATA_W-1];
    endcase
  end

  assign sbit = sgn & top;

  for (genvar k = 0; k < BYTES; k++) begin : g_ld_lane
    assign ldata[8*k +: 8] = (4'(k) < size) ? win[8*k +: 8] : {8{sbit}};
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: request/response handshake, one or two memory
// beats per access, lane steering delegated to lsu_lane_shift.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 32,
  parameter  int SPLIT_EN = 1,
  localparam int BYTES    = DATA_W / 8,
  localparam int OFF_W    = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BYTES-1:0]  mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  lsu_state_e state_q, state_d;

  logic              r_we, r_sgn, r_cross;
  logic [3:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] lo, hi;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  lsu_dec_t          dec;
  logic [4:0]        end_in;
  logic              cross_in, err_in, accept;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] lo_src, hi_src;
  logic [BYTES-1:0]  be_lo, be_hi;
  logic [DATA_W-1:0] wd_lo, wd_hi, ldata;

  assign dec      = size_decode(req_we, req_func3, DATA_W == 64);
  assign end_in   = 5'(req_addr[OFF_W-1:0]) + 5'(dec.size);
  assign cross_in = end_in > 5'(BYTES);
  assign err_in   = !dec.legal || (cross_in && SPLIT_EN == 0);
  assign accept   = req_valid && (state_q == S_IDLE);

  assign base_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // forward the beat being captured so the result can be registered on RESP entry
  assign lo_src = (state_q == S_WAIT0) ? mem_rdata : lo;
  assign hi_src = (state_q == S_WAIT1) ? mem_rdata : hi;

  lsu_lane_shift #(.DATA_W(DATA_W)) u_shift (
    .off   (r_addr[OFF_W-1:0]),
    .size  (r_size),
    .sgn   (r_sgn),
    .wdata (r_wdata),
    .lo    (lo_src),
    .hi    (hi_src),
    .be_lo (be_lo),
    .be_hi (be_hi),
    .wd_lo (wd_lo),
    .wd_hi (wd_hi),
    .ldata (ldata)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_be        = '0;
    mem_wdata     = '0;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = err_in ? S_RESP : S_REQ0;
      S_REQ0: begin
        mem_req_valid = 1'b1;
        mem_addr      = base_addr;
        mem_we        = r_we;
        mem_be        = r_we ? be_lo : {BYTES{1'b1}};
        mem_wdata     = r_we ? wd_lo : '0;
        if (mem_req_ready) state_d = S_WAIT0;
      end
      S_WAIT0: if (mem_rvalid) state_d = r_cross ? S_REQ1 : S_RESP;
      S_REQ1: begin
        mem_req_valid = 1'b1;
        mem_addr      = base_addr + ADDR_W'(BYTES);
        mem_we        = r_we;
        mem_be        = r_we ? be_hi : {BYTES{1'b1}};
        mem_wdata     = r_we ? wd_hi : '0;
        if (mem_req_ready) state_d = S_WAIT1;
      end
      S_WAIT1: if (mem_rvalid) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_we       <= 1'b0;
      r_sgn      <= 1'b0;
      r_cross    <= 1'b0;
      r_size     <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      lo         <= '0;
      hi         <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r_we       <= req_we;
        r_sgn      <= dec.sgn;
        r_cross    <= cross_in;
        r_size     <= dec.size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        rsp_err_q  <= err_in;
        rsp_data_q <= '0;
      end
      if (state_q == S_WAIT0 && mem_rvalid) lo <= mem_rdata;
      if (state_q == S_WAIT1 && mem_rvalid) hi <= mem_rdata;
      if (state_d == S_RESP && (state_q == S_WAIT0 || state_q == S_WAIT1))
        rsp_data_q <= r_we ? '0 : ldata;
      if (state_q == S_RESP && rsp_ready) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
